// File: rtl/y_integ_top.sv
// Y-matrix update engine: captures one change record per pass, read-modify-writes
// the addressed complex entry in memory and reports the result with a done pulse.

module y_integ_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clock,
  input  logic          i_rd_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [255:0]  i_wdata,
  output logic [255:0]  o_rdata
);
  // Contents survive reset; preloaded externally through this array's hierarchy.
  logic [255:0] Register [0:DEPTH-1];
  logic [255:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) Register[i_addr] <= i_wdata;
    if (i_rd_en) r_rdata <= Register[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

module y_integ_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clock,
  input  logic          i_rd_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [255:0]  i_wdata,
  output logic [255:0]  o_rdata
);
  y_integ_ram #(.DEPTH(DEPTH), .AW(AW)) Y1 (
    .clock   (clock),
    .i_rd_en (i_rd_en),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata)
  );
endmodule

module y_integ_top #(
  parameter int NROWS = 64,
  parameter int NCOLS = 16,
  parameter int DEPTH = 256,
  parameter int DW    = 24
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [15:0]     top_chgTxt_row,
  input  logic [15:0]     top_chgTxt_col,
  input  logic [DW-1:0]   top_chgTxt_real,
  input  logic [DW-1:0]   top_chgTxt_img,
  output logic            writeDoneFlag,
  output logic [2*DW-1:0] top_opYval
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(NROWS);
  localparam int CW = $clog2(NCOLS);

  typedef enum logic [2:0] {
    S_CAPTURE,
    S_READ,
    S_MODIFY,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [15:0]     r_row;
  logic [15:0]     r_col;
  logic [DW-1:0]   r_dreal;
  logic [DW-1:0]   r_dimag;
  logic [DW-1:0]   r_new_real;
  logic [DW-1:0]   r_new_imag;
  logic            r_done;
  logic [2*DW-1:0] r_opyval;

  logic            w_in_range;
  logic            w_rd_en;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  logic [1:0]      w_slot;
  logic [255:0]    w_rdata;
  logic [255:0]    w_wdata;
  logic [63:0]     w_slots [0:3];
  logic [DW-1:0]   w_old_real;
  logic [DW-1:0]   w_old_imag;

  assign w_in_range = (r_row < 16'(NROWS)) && (r_col < 16'(NCOLS));
  assign w_addr     = AW'(r_row[RW-1:0]) * AW'(NCOLS / 4) + AW'(r_col[CW-1:0] >> 2);
  assign w_slot     = r_col[1:0];
  assign w_old_real = w_slots[w_slot][2*DW-1:DW];
  assign w_old_imag = w_slots[w_slot][DW-1:0];

  // Only the addressed slot's payload is replaced; reserved bits and other slots pass through.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      assign w_slots[gi] = w_rdata[64*gi +: 64];
      assign w_wdata[64*gi +: 64] = (w_slot == 2'(gi)) ?
                                    {w_slots[gi][63:2*DW], r_new_real, r_new_imag} :
                                    w_slots[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_CAPTURE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_we         = 1'b0;
    case (r_state)
      S_CAPTURE: w_state_next = S_READ;
      S_READ: begin
        w_rd_en      = 1'b1;
        w_state_next = S_MODIFY;
      end
      S_MODIFY: w_state_next = S_WRITE;
      S_WRITE: begin
        // A reset landing on the write edge aborts the write as well.
        w_we         = w_in_range & reset;
        w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_CAPTURE;
      default: w_state_next = S_CAPTURE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_done   <= 1'b0;
      r_opyval <= '0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_WRITE)
        r_opyval <= w_in_range ? {r_new_real, r_new_imag} : '0;
    end
    if (r_state == S_CAPTURE) begin
      r_row   <= top_chgTxt_row;
      r_col   <= top_chgTxt_col;
      r_dreal <= top_chgTxt_real;
      r_dimag <= top_chgTxt_img;
    end
    if (r_state == S_MODIFY) begin
      r_new_real <= w_old_real + r_dreal;
      r_new_imag <= w_old_imag + r_dimag;
    end
  end

  y_integ_mem #(.DEPTH(DEPTH), .AW(AW)) memory_inst (
    .clock   (clock),
    .i_rd_en (w_rd_en),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign writeDoneFlag = r_done;
  assign top_opYval    = r_opyval;
endmodule

// File: tb/tb_y_integ_top.sv
// Randomized bench for y_integ_top against an array-based model of the Y-matrix
// memory; one line per update, FAIL lines on any mismatch.

module tb_y_integ_top;
  localparam int NROWS = 64;
  localparam int NCOLS = 16;
  localparam int DEPTH = 256;
  localparam int DW    = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   row   = '0;
  logic [15:0]   col   = '0;
  logic [DW-1:0] dreal = '0;
  logic [DW-1:0] dimag = '0;
  logic          done;
  logic [47:0]   opy;

  always #5 clock = ~clock;

  y_integ_top #(.NROWS(NROWS), .NCOLS(NCOLS), .DEPTH(DEPTH), .DW(DW)) dut (
    .clock           (clock),
    .reset           (reset),
    .top_chgTxt_row  (row),
    .top_chgTxt_col  (col),
    .top_chgTxt_real (dreal),
    .top_chgTxt_img  (dimag),
    .writeDoneFlag   (done),
    .top_opYval      (opy)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [255:0] m_mem [0:DEPTH-1];
  logic [47:0]  m_out;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input int r, input int c);
    return (r < NROWS) && (c < NCOLS);
  endfunction

  function automatic int word_of(input int r, input int c);
    return r * (NCOLS / 4) + c / 4;
  endfunction

  task automatic preload_slot(input int r, input int c, input logic [23:0] re, input logic [23:0] im);
    int a = word_of(r, c);
    int s = c % 4;
    m_mem[a][64*s+24 +: 24] = re;
    m_mem[a][64*s +: 24]    = im;
    dut.memory_inst.Y1.Register[a] = m_mem[a];
  endtask

  task automatic model_update(input int r, input int c, input logic [23:0] dr, input logic [23:0] di);
    int a, s;
    logic [23:0] nre, nim;
    if (in_range(r, c)) begin
      a   = word_of(r, c);
      s   = c % 4;
      nre = m_mem[a][64*s+24 +: 24] + dr;
      nim = m_mem[a][64*s +: 24] + di;
      m_mem[a][64*s+24 +: 24] = nre;
      m_mem[a][64*s +: 24]    = nim;
      m_out = {nre, nim};
    end else begin
      m_out = '0;
    end
  endtask

  // Called in a capture cycle (#1 after an edge); returns in the next capture cycle.
  task automatic run_update(input string tag, input int r, input int c,
                            input logic [23:0] dr, input logic [23:0] di);
    int edges = 0;
    bit seen = 0;
    row = 16'(r); col = 16'(c); dreal = dr; dimag = di;
    model_update(r, c, dr, di);
    while (!seen && edges < 12) begin
      @(posedge clock);
      #1;
      edges++;
      if (done === 1'b1) seen = 1;
    end
    check_val({tag, "_lat"}, 256'(edges), 256'(5));
    check_val({tag, "_out"}, 256'(opy), 256'(m_out));
    if (in_range(r, c))
      check_val({tag, "_mem"}, dut.memory_inst.Y1.Register[word_of(r, c)], m_mem[word_of(r, c)]);
    $display("update %s row=%0d col=%0d d=%h/%h out=%h exp=%h", tag, r, c, dr, di, opy, m_out);
  endtask

  task automatic check_all_mem(input string tag);
    int ndiff = 0;
    for (int i = 0; i < DEPTH; i++)
      if (dut.memory_inst.Y1.Register[i] !== m_mem[i]) ndiff++;
    check_val(tag, 256'(ndiff), 256'(0));
  endtask

  initial begin
    int r, c;
    logic [23:0] base_re, base_im;

    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      dut.memory_inst.Y1.Register[i] = m_mem[i];
    end
    preload_slot(0, 0, 24'h000010, 24'h000020);
    preload_slot(3, 1, 24'h7FFFFF, 24'h800000);
    preload_slot(7, 10, 24'h000100, 24'hFFFF00);

    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_val("rst_done", 256'(done), 256'(0));
      check_val("rst_out", 256'(opy), 256'(0));
    end
    reset = 1'b1;

    run_update("basic", 0, 0, 24'h000005, 24'hFFFFFF);
    check_val("basic_const", 256'(opy), 256'(48'h000015_00001F));
    run_update("map", 2, 7, 24'h012345, 24'h00ABCD);
    run_update("wrap", 3, 1, 24'h000001, 24'hFFFFFF);
    check_val("wrap_const", 256'(opy), 256'(48'h800000_7FFFFF));

    base_re = m_mem[word_of(7, 10)][64*2+24 +: 24];
    base_im = m_mem[word_of(7, 10)][64*2 +: 24];
    run_update("acc1", 7, 10, 24'd1, 24'd1);
    run_update("acc2", 7, 10, 24'd2, 24'd2);
    run_update("acc3", 7, 10, 24'd3, 24'd3);
    check_val("acc_total", 256'(opy), 256'({base_re + 24'd6, base_im + 24'd6}));

    run_update("oor_row", 64, 3, 24'h000111, 24'h000222);
    run_update("oor_col", 5, 16, 24'h000333, 24'h000444);
    check_all_mem("oor_mem");

    // Reset lands on the edge that ends MODIFY: nothing may be written or reported.
    run_update("pre_abort", 9, 9, 24'h000050, 24'h000060);
    row = 16'd9; col = 16'd9; dreal = 24'h000700; dimag = 24'h000800;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_val("abort_done", 256'(done), 256'(0));
      check_val("abort_out", 256'(opy), 256'(0));
    end
    check_all_mem("abort_mem");
    reset = 1'b1;
    run_update("post_abort", 9, 9, 24'h000001, 24'h000001);

    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 4) begin
        r = 9; c = 9;
      end else begin
        r = int'($urandom_range(0, 67));
        c = int'($urandom_range(0, 17));
      end
      run_update($sformatf("rnd%0d", i), r, c, 24'($urandom), 24'($urandom));
    end
    check_all_mem("final_mem");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
